inst_fetcher: RTL

Front-end fetch stage that sits directly upstream of the decoder. It holds the architectural fetch PC and issues one instruction-fetch request at a time to the memory/icache port. It presents each returned instruction, with its address, to the decoder, then takes the decoder's combinational next-PC to form the following fetch. It also handles decoder stalls, back-pressure and ROB-initiated flushes, including discarding a stale in-flight response.

---
 rtl/inst_fetcher.sv | 107 ++++++++++
 1 files changed

// File: rtl/inst_fetcher.sv
// Fetch stage: one outstanding icache request at a time, presents the returned
// instruction to the decoder and follows its next-PC; handles stall, flush and drain.
module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        _mem_req,
  output logic [31:0] _mem_addr,
  input  logic        _mem_gnt,
  input  logic        _mem_valid,
  input  logic [31:0] _mem_data,
  output logic [31:0] _inst,
  output logic [31:0] _inst_addr,
  output logic        _inst_ready,
  input  logic [31:0] _next_pc,
  input  logic        _stall,
  input  logic        _full,
  input  logic        _clear,
  input  logic [31:0] _clear_pc,
  output logic [31:0] _fetch_cnt
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned HLEN = 16;

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   cnt_q, cnt_d;
  logic              accept;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: a flush overrides everything; rdy_in low freezes the block.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (rdy_in) begin
      if (_clear) begin
        pc_d = _clear_pc;
        unique case (state_q)
          REQ:     state_d = _mem_gnt ? DRAIN : REQ;
          WAIT:    state_d = _mem_valid ? REQ : DRAIN;
          HOLD:    state_d = REQ;
          DRAIN:   state_d = DRAIN;
          default: state_d = REQ;
        endcase
      end else begin
        unique case (state_q)
          REQ: begin
            if (_mem_gnt) state_d = WAIT;
          end
          WAIT: begin
            if (_mem_valid) begin
              state_d = HOLD;
              // Low two bits != 2'b11 marks a compressed 16-bit instruction.
              if (_mem_data[1:0] != 2'b11)
                inst_d = {HLEN'(0), _mem_data[HLEN-1:0]};
              else
                inst_d = _mem_data;
            end
          end
          HOLD: begin
            accept = !_stall && !_full;
            if (accept) begin
              state_d = REQ;
              pc_d    = _next_pc;
              cnt_d   = cnt_q + XLEN'(1);
            end
          end
          DRAIN: begin
            if (_mem_valid) state_d = REQ;
          end
          default: state_d = REQ;
        endcase
      end
    end
  end

  // Handshake outputs decode registered state; only rdy_in (and reset) gate them.
  assign _mem_req    = rdy_in && rst_in && (state_q == REQ);
  assign _mem_addr   = pc_q;
  assign _inst_ready = rdy_in && (state_q == HOLD);
  assign _inst_addr  = pc_q;
  assign _inst       = inst_q;
  assign _fetch_cnt  = cnt_q;

endmodule
